// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: LC-3b word/mask types, arbiter states
// and the latched physical-memory request payload.
package mem_arbiter_pkg;

  localparam int unsigned WORD_W   = 16;
  localparam int unsigned WMASK_W  = 2;
  localparam int unsigned STREAK_W = 4;

  typedef logic [WORD_W-1:0]  lc3b_word;
  typedef logic [WMASK_W-1:0] lc3b_mem_wmask;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_I,
    ARB_SERVE_D
  } mem_arb_state_t;

  // Everything presented on pmem_* for the duration of one transaction
  typedef struct packed {
    logic          read;
    logic          write;
    lc3b_mem_wmask wmask;
    lc3b_word      address;
    lc3b_word      wdata;
  } pmem_req_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the pipeline's instruction and data memory ports onto a single
// physical memory port; data wins, with a streak limit so fetches still progress.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               i_read,
  input  logic [WORD_W-1:0]  i_address,
  output logic [WORD_W-1:0]  i_rdata,
  output logic               i_resp,

  input  logic               d_read,
  input  logic               d_write,
  input  logic [WMASK_W-1:0] d_wmask,
  input  logic [WORD_W-1:0]  d_address,
  input  logic [WORD_W-1:0]  d_wdata,
  output logic [WORD_W-1:0]  d_rdata,
  output logic               d_resp,

  output logic               pmem_read,
  output logic               pmem_write,
  output logic [WMASK_W-1:0] pmem_wmask,
  output logic [WORD_W-1:0]  pmem_address,
  output logic [WORD_W-1:0]  pmem_wdata,
  input  logic [WORD_W-1:0]  pmem_rdata,
  input  logic               pmem_resp
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  mem_arb_state_t      state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  pmem_req_t           req_q, req_d;
  logic                d_pend, i_pend, grant_i;

  // State, streak and latched request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      streak_q <= '0;
      req_q    <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      req_q    <= req_d;
    end
  end

  // Arbitration and completion; requester inputs only matter in IDLE
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    req_d    = req_q;
    d_pend   = d_read | d_write;
    i_pend   = i_read;
    grant_i  = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        grant_i = i_pend && (!d_pend || (streak_q == STREAK_MAX));
        if (grant_i) begin
          state_d       = ARB_SERVE_I;
          streak_d      = '0;
          req_d.read    = 1'b1;
          req_d.write   = 1'b0;
          req_d.wmask   = '0;
          req_d.address = i_address;
          req_d.wdata   = '0;
        end else if (d_pend) begin
          state_d       = ARB_SERVE_D;
          if (!i_pend) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + STREAK_W'(1);
          end
          // A simultaneous read and write is issued as the write
          req_d.read    = !d_write;
          req_d.write   = d_write;
          req_d.wmask   = d_write ? d_wmask : '0;
          req_d.address = d_address;
          req_d.wdata   = d_wdata;
        end
      end
      ARB_SERVE_I, ARB_SERVE_D: begin
        if (pmem_resp) begin
          state_d     = ARB_IDLE;
          req_d.read  = 1'b0;
          req_d.write = 1'b0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign pmem_read    = req_q.read;
  assign pmem_write   = req_q.write;
  assign pmem_wmask   = req_q.wmask;
  assign pmem_address = req_q.address;
  assign pmem_wdata   = req_q.wdata;

  // Completion is passed straight through to release the pipeline stall
  assign i_resp  = (state_q == ARB_SERVE_I) && pmem_resp;
  assign d_resp  = (state_q == ARB_SERVE_D) && pmem_resp;
  assign i_rdata = i_resp ? pmem_rdata : '0;
  assign d_rdata = d_resp ? pmem_rdata : '0;

endmodule
